// File: rtl/mult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mult_rr_arbiter
//   Shares one N x N unsigned multiplier among R requesters. Each requester
//   offers an operand pair over valid/ready. A round-robin arbiter grants at
//   most one requester per cycle. The granted pair then passes through a
//   2-stage pipeline: an operand register, then a product register. Every
//   product is returned tagged with the ID of the requester that issued it.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous, active-low reset
//   req_valid  [R]      requester i presents an operand pair
//   req_a      [R*N]    operand a of requester i in bits [i*N +: N]
//   req_b      [R*N]    operand b of requester i in bits [i*N +: N]
//   req_ready  [R]      one-hot or zero, grant for this cycle
//   res_valid  [1]      result present
//   res_id     [IW]     requester that issued the result
//   res_p      [2N]     unsigned product a*b
//   res_ready  [1]      consumer accepts the result this cycle
//   busy       [1]      any pipeline stage holds a valid entry
// -----------------------------------------------------------------------------

// Shared combinational multiplier core. Both operands are zero-extended so
// that the full 2N-bit product is kept.
module multiplier #(
  parameter int N = 8
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  assign p = {{N{1'b0}}, a} * {{N{1'b0}}, b};

endmodule

module mult_rr_arbiter #(
  parameter  int N  = 8,
  parameter  int R  = 4,
  localparam int IW = (R > 1) ? $clog2(R) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req_valid,
  input  logic [R*N-1:0] req_a,
  input  logic [R*N-1:0] req_b,
  output logic [R-1:0]   req_ready,
  output logic           res_valid,
  output logic [IW-1:0]  res_id,
  output logic [2*N-1:0] res_p,
  input  logic           res_ready,
  output logic           busy
);

  logic           s1_valid;
  logic [IW-1:0]  s1_id;
  logic [N-1:0]   s1_a;
  logic [N-1:0]   s1_b;
  logic           s2_valid;
  logic [IW-1:0]  s2_id;
  logic [2*N-1:0] s2_p;
  logic [IW-1:0]  last_grant;

  logic           adv;
  logic           grant_any;
  logic [IW-1:0]  grant_id;
  logic [N-1:0]   grant_a;
  logic [N-1:0]   grant_b;
  logic [IW-1:0]  cand;
  logic [2*N-1:0] mul_p;

  logic [N-1:0]   a_arr [R];
  logic [N-1:0]   b_arr [R];

  // Unpack the flat operand buses so the granted pair can be selected by ID.
  always_comb begin
    for (int i = 0; i < R; i++) begin
      a_arr[i] = req_a[i*N +: N];
      b_arr[i] = req_b[i*N +: N];
    end
  end

  // The whole pipeline moves together; a held result at the output freezes
  // both stages and suppresses any grant, which backpressures every requester.
  // The search starts one past the last granted requester and wraps, so the
  // most recently served requester always has the lowest priority.
  always_comb begin
    adv       = !(s2_valid && !res_ready);
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    grant_a   = '0;
    grant_b   = '0;
    cand      = '0;
    if (adv) begin
      for (int k = 1; k <= R; k++) begin
        cand = IW'((int'(last_grant) + k) % R);
        if (!grant_any && req_valid[cand]) begin
          grant_any       = 1'b1;
          grant_id        = cand;
          grant_a         = a_arr[cand];
          grant_b         = b_arr[cand];
          req_ready[cand] = 1'b1;
        end
      end
    end
  end

  multiplier #(.N(N)) u_multiplier (
    .a (s1_a),
    .b (s1_b),
    .p (mul_p)
  );

  // Pipeline registers and round-robin pointer. Operands are zeroed on an
  // idle cycle so that an empty slot carries a zero product. The pointer
  // resets to R-1 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      s2_id      <= '0;
      s2_p       <= '0;
      last_grant <= IW'(R - 1);
    end else if (adv) begin
      s1_valid <= grant_any;
      s1_id    <= grant_id;
      s1_a     <= grant_a;
      s1_b     <= grant_b;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_p     <= mul_p;
      if (grant_any) begin
        last_grant <= grant_id;
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_id    = s2_id;
  assign res_p     = s2_p;
  assign busy      = s1_valid | s2_valid;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_rr_arbiter
//   Self-checking bench for mult_rr_arbiter. A behavioural model tracks the
//   round-robin pointer and the two in-flight slots. Each test task compares
//   the DUT against that model every cycle and adds directed checks of its own.
// -----------------------------------------------------------------------------
module tb_mult_rr_arbiter;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int IW = 2;
  localparam int VW = R + 1 + IW + 2*N + 1;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_a;
  logic [R*N-1:0] req_b;
  logic [R-1:0]   req_ready;
  logic           res_valid;
  logic [IW-1:0]  res_id;
  logic [2*N-1:0] res_p;
  logic           res_ready;
  logic           busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: round-robin pointer plus the two in-flight slots.
  // Slot 0 holds the entry granted last cycle and slot 1 the entry at the
  // output. Products are computed with plain integer arithmetic.
  int           m_last;
  bit           pv  [2];
  int           pid [2];
  int           pp  [2];
  bit           exp_adv;
  int           exp_grant;
  logic [R-1:0] exp_ready;
  logic [VW-1:0] exp_vec;
  int           grants [$];

  mult_rr_arbiter #(.N(N), .R(R)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_p     (res_p),
    .res_ready (res_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [R-1:0] v, input int last);
    int idx;
    for (int k = 1; k <= R; k++) begin
      idx = (last + k) % R;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // res_id carries no meaning while no result is present, so it is masked.
  function automatic logic [VW-1:0] observed();
    return {req_ready, res_valid, (pv[1] ? res_id : {IW{1'b0}}), res_p, busy};
  endfunction

  task automatic model_reset();
    m_last = R - 1;
    for (int i = 0; i < 2; i++) begin
      pv[i]  = 1'b0;
      pid[i] = 0;
      pp[i]  = 0;
    end
  endtask

  task automatic predict();
    exp_adv   = !(pv[1] && !res_ready);
    exp_grant = exp_adv ? rr_pick(req_valid, m_last) : -1;
    exp_ready = '0;
    if (exp_grant >= 0) exp_ready[exp_grant] = 1'b1;
    exp_vec = {exp_ready, pv[1], IW'(pid[1]), (2*N)'(pp[1]), pv[0] | pv[1]};
  endtask

  task automatic advance();
    if (exp_adv) begin
      pv[1]  = pv[0];
      pid[1] = pid[0];
      pp[1]  = pp[0];
      if (exp_grant >= 0) begin
        pv[0]  = 1'b1;
        pid[0] = exp_grant;
        pp[0]  = int'(req_a[exp_grant*N +: N]) * int'(req_b[exp_grant*N +: N]);
        m_last = exp_grant;
        grants.push_back(exp_grant);
      end else begin
        pv[0]  = 1'b0;
        pid[0] = 0;
        pp[0]  = 0;
      end
    end
  endtask

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  task automatic apply_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({req_ready, res_valid, res_id, res_p, busy} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_state got %h required 0",
               {req_ready, res_valid, res_id, res_p, busy});
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    model_reset();
    req_valid = 4'b0001;
    set_req(0, 8'd12, 8'd13);
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL basic_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      if (cyc == 0) begin
        n_checks++;
        if (req_ready !== 4'b0001) begin
          n_fail++;
          $display("[TB] FAIL basic_grant got %b required 0001", req_ready);
        end
      end
      if (cyc == 2) begin
        n_checks++;
        if ({res_valid, res_id, res_p} !== {1'b1, 2'd0, 16'd156}) begin
          n_fail++;
          $display("[TB] FAIL basic_result got v=%b id=%0d p=%0d required v=1 id=0 p=156",
                   res_valid, res_id, res_p);
        end
      end
      if (cyc == 3) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL basic_busy_fall got %b required 0", busy);
        end
      end
      @(posedge clk);
      advance();
      #1;
      req_valid = '0;
    end
  endtask

  task automatic test_fairness();
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};
    apply_reset();
    grants.delete();
    for (int i = 0; i < R; i++) set_req(i, N'(17 * i + 3), N'(29 * i + 5));
    for (int cyc = 0; cyc < 9; cyc++) begin
      req_valid = (cyc < 6) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL fairness_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      @(posedge clk);
      advance();
      #1;
    end
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (grants.size() <= k || grants[k] != exp_order[k]) begin
        n_fail++;
        $display("[TB] FAIL fairness_order idx%0d got %0d required %0d", k,
                 (grants.size() > k) ? grants[k] : -1, exp_order[k]);
      end
    end
  endtask

  task automatic test_max();
    set_req(2, 8'd255, 8'd255);
    for (int cyc = 0; cyc < 4; cyc++) begin
      req_valid = (cyc == 0) ? 4'b0100 : 4'b0000;
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL max_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      if (cyc == 2) begin
        n_checks++;
        if ({res_valid, res_id, res_p} !== {1'b1, 2'd2, 16'hFE01}) begin
          n_fail++;
          $display("[TB] FAIL max_product got v=%b id=%0d p=%h required v=1 id=2 p=fe01",
                   res_valid, res_id, res_p);
        end
      end
      @(posedge clk);
      advance();
      #1;
    end
  endtask

  task automatic test_stall();
    int pops;
    pops = 0;
    for (int i = 0; i < R; i++) set_req(i, N'(40 + i), N'(90 - i));
    for (int cyc = 0; cyc < 9; cyc++) begin
      req_valid = (cyc < 5) ? 4'b1111 : 4'b0000;
      res_ready = (cyc >= 2 && cyc <= 4) ? 1'b0 : 1'b1;
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL stall_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (req_ready !== 4'b0000 || res_valid !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL stall_hold cyc%0d got ready=%b v=%b required ready=0000 v=1",
                   cyc, req_ready, res_valid);
        end
      end
      if (cyc >= 5 && res_valid === 1'b1) pops++;
      @(posedge clk);
      advance();
      #1;
    end
    n_checks++;
    if (pops != 2) begin
      n_fail++;
      $display("[TB] FAIL stall_release_count got %0d required 2", pops);
    end
    res_ready = 1'b1;
  endtask

  task automatic test_alternate();
    int exp_order [4] = '{3, 1, 3, 1};
    apply_reset();
    set_req(1, 8'd7, 8'd9);
    set_req(3, 8'd200, 8'd3);
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc == 0)     req_valid = 4'b0010;
      else if (cyc < 5) req_valid = 4'b1010;
      else              req_valid = 4'b0000;
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL alternate_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      @(posedge clk);
      advance();
      #1;
      if (cyc == 0) grants.delete();
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (grants.size() <= k || grants[k] != exp_order[k]) begin
        n_fail++;
        $display("[TB] FAIL alternate_order idx%0d got %0d required %0d", k,
                 (grants.size() > k) ? grants[k] : -1, exp_order[k]);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < R; i++) set_req(i, N'(11 + i), N'(23 + i));
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int cyc = 0; cyc < 2; cyc++) begin
      @(negedge clk);
      predict();
      @(posedge clk);
      advance();
      #1;
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset got v=%b busy=%b required v=0 busy=0", res_valid, busy);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      req_valid = (cyc == 0) ? 4'b1111 : 4'b0000;
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL async_reset_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      if (cyc == 0) begin
        n_checks++;
        if (req_ready !== 4'b0001) begin
          n_fail++;
          $display("[TB] FAIL async_reset_first_grant got %b required 0001", req_ready);
        end
      end
      @(posedge clk);
      advance();
      #1;
    end
  endtask

  task automatic test_random();
    bit           pend [R];
    logic [N-1:0] pa   [R];
    logic [N-1:0] pb   [R];
    for (int i = 0; i < R; i++) pend[i] = 1'b0;
    for (int cyc = 0; cyc < 303; cyc++) begin
      for (int i = 0; i < R; i++) begin
        if (!pend[i] && cyc < 300 && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i]   = ($urandom_range(0, 7) == 0) ? 8'd255 : N'($urandom_range(0, 255));
          pb[i]   = ($urandom_range(0, 7) == 0) ? 8'd255 : N'($urandom_range(0, 255));
        end
        req_valid[i] = pend[i];
        set_req(i, pa[i], pb[i]);
      end
      res_ready = (cyc >= 300) ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      predict();
      n_checks++;
      if (observed() !== exp_vec) begin
        n_fail++;
        $display("[TB] FAIL random_model cyc%0d got %h required %h", cyc, observed(), exp_vec);
      end
      @(posedge clk);
      advance();
      #1;
      if (exp_grant >= 0) pend[exp_grant] = 1'b0;
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fairness();
    test_max();
    test_stall();
    test_alternate();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
